// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types and constants for the request arbiter
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Index width for n requesters; a single requester still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pri_enc.sv
// rtl/pri_enc.sv - lowest-index-first priority encoder with valid flag
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module pri_enc
    import arb_pkg::*;
#(
    parameter int   IN  = 8,
    parameter logic ACT = `High,
    parameter int   OUT = idx_w(IN)
) (
    input  logic [IN-1:0]  vec_i,
    output logic           valid_o,
    output logic [OUT-1:0] idx_o
);

    logic [IN-1:0] nvec;

    assign nvec = (ACT == `High) ? vec_i : ~vec_i;

    // Scanning downward lets the lowest set bit overwrite any higher one.
    always_comb begin
        valid_o = 1'b0;
        idx_o   = '0;
        for (int i = IN - 1; i >= 0; i--) begin
            if (nvec[i]) begin
                valid_o = 1'b1;
                idx_o   = OUT'(i);
            end
        end
    end

endmodule

// File: rtl/rr_pri_arb.sv
// rtl/rr_pri_arb.sv - fixed-priority / round-robin arbiter with held grants
`ifndef High
`define High 1'b1
`endif
`ifndef Low
`define Low 1'b0
`endif

module rr_pri_arb
    import arb_pkg::*;
#(
    parameter int   REQ  = 8,
    parameter int   OUT  = idx_w(REQ),
    parameter logic ACT  = `High,
    parameter int   MODE = ARB_RR
) (
    input  logic           clk,
    input  logic           reset_,
    input  logic [REQ-1:0] req,
    input  logic           last,
    output logic           grant_valid,
    output logic [REQ-1:0] grant,
    output logic [OUT-1:0] grant_idx
);

    arb_state_t     state_q;
    logic [OUT-1:0] ptr_q;
    logic [OUT-1:0] ptr_d;

    logic [REQ-1:0] nreq;
    logic [REQ-1:0] hold_mask;
    logic [REQ-1:0] cand;
    logic [REQ-1:0] ptr_mask;
    logic [REQ-1:0] mcand;
    logic [REQ-1:0] win_onehot;
    logic           m_valid;
    logic           u_valid;
    logic [OUT-1:0] m_idx;
    logic [OUT-1:0] u_idx;
    logic [OUT-1:0] win_idx;
    logic           rel;
    logic           arb_en;

    assign nreq = (ACT == `High) ? req : ~req;

    // The current holder is excluded so a release never re-grants it back to back.
    always_comb begin
        hold_mask = '0;
        if (state_q == ARB_BUSY) begin
            hold_mask[grant_idx] = 1'b1;
        end
        cand = nreq & ~hold_mask;
        for (int i = 0; i < REQ; i++) begin
            ptr_mask[i] = (MODE == ARB_RR) && (i >= int'(ptr_q));
        end
        mcand = cand & ptr_mask;
    end

    pri_enc #(.IN(REQ), .ACT(`High), .OUT(OUT)) u_enc_masked (
        .vec_i   (mcand),
        .valid_o (m_valid),
        .idx_o   (m_idx)
    );

    pri_enc #(.IN(REQ), .ACT(`High), .OUT(OUT)) u_enc_full (
        .vec_i   (cand),
        .valid_o (u_valid),
        .idx_o   (u_idx)
    );

    always_comb begin
        win_idx = m_valid ? m_idx : u_idx;
        win_onehot = '0;
        win_onehot[win_idx] = 1'b1;
        if (int'(win_idx) == REQ - 1) begin
            ptr_d = '0;
        end else begin
            ptr_d = win_idx + OUT'(1);
        end
    end

    assign rel    = (state_q == ARB_BUSY) && (last || !nreq[grant_idx]);
    assign arb_en = (state_q == ARB_IDLE) || rel;

    always_ff @(posedge clk) begin
        if (!reset_) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            grant_valid <= 1'b0;
            grant       <= '0;
            grant_idx   <= '0;
        end else if (arb_en) begin
            if (u_valid) begin
                state_q     <= ARB_BUSY;
                grant_valid <= 1'b1;
                grant       <= win_onehot;
                grant_idx   <= win_idx;
                if (MODE == ARB_RR) begin
                    ptr_q <= ptr_d;
                end
            end else begin
                state_q     <= ARB_IDLE;
                grant_valid <= 1'b0;
                grant       <= '0;
                grant_idx   <= '0;
            end
        end
    end

endmodule
